sensefiltsync: RTL
==================

// Module: sensefiltsync
// PURPOSE
//  Multi-channel successor to the single-bit sense-input synchroniser.
//  - Brings CHANNELS asynchronous sense inputs into the clk_sampler domain through a
//    SYNC_STAGES-deep flop chain.
//  - Applies a per-channel stability (glitch) filter of FILT_LEN cycles.
//  - Optionally emits one-cycle rise/fall pulses.
//  - Sits at the chip boundary, ahead of the sampler control logic.
// PARAMETERS
//  CHANNELS     4  number of independent sense inputs (>=1)
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  FILT_LEN     4  consecutive cycles a synced value must differ before it is accepted (>=1)
// PORTS
//  clk_sampler                           in   1         sampler clock, the only clock
//  rst_sampler_sync                      in   1         async-assert reset, active-high
//  sense_in                              in   CHANNELS  asynchronous sense inputs
//  sensefiltsync_sampler_sense_in_r_sync out  CHANNELS  synchronised and filtered level
//  sensefiltsync_sampler_sense_in_rise   out  CHANNELS  1-cycle pulse, filtered 0->1
//  sensefiltsync_sampler_sense_in_fall   out  CHANNELS  1-cycle pulse, filtered 1->0
// BEHAVIOUR
//  - One clock (clk_sampler). Reset is asynchronous and active-high (rst_sampler_sync).
//  - Reset clears all of the following to 0 immediately, independent of the clock:
//    sync chains, filter counters, filtered levels and pulses.
//  - Every output reads 0 while reset is high.
//  - Channels are fully independent; there is no cross-channel interaction.
//  - Sync chain per channel: stage[0] <= sense_in[i]; stage[k] <= stage[k-1].
//    s[i] = stage[SYNC_STAGES-1]. No logic is placed between sync flops.
//  - Filter per channel: counter cnt, width max(1,$clog2(FILT_LEN)); filtered level f.
//    Rules, evaluated on each clk_sampler edge:
//    * s == f                 : cnt <= 0.
//    * s != f, cnt < FILT_LEN-1 : cnt <= cnt+1.
//    * s != f, cnt == FILT_LEN-1 : f <= s, cnt <= 0 ("update").
//  - With FILT_LEN=1 the filter degenerates to one extra register stage.
//  - Latency: a level held stable at sense_in appears on r_sync exactly
//    SYNC_STAGES+FILT_LEN rising edges after the first edge that captures it.
//    Defaults give 6 edges.
//  - Glitch rejection: any excursion of s lasting < FILT_LEN cycles leaves f unchanged.
//    The counter restarts from 0 on the next differing cycle. An excursion of exactly
//    FILT_LEN cycles is accepted.
//  - Pulses are registered on the same edge that f updates, so a pulse is high in the
//    first cycle f shows its new value:
//    * rise[i] <= update & s[i];  fall[i] <= update & ~s[i]; 0 on all other cycles.
//    * rise and fall are never high together on a channel.
//    * Pulses on consecutive cycles are impossible when FILT_LEN>1.
//  - Reset mid-count discards the partial count. After release, f starts from 0, so an
//    input that is already high produces a rise pulse SYNC_STAGES+FILT_LEN edges later.
//  - Illegal parameters (SYNC_STAGES<2, FILT_LEN<1, CHANNELS<1) raise an elaboration
//    error via a generate-time $error.
// CONFIGURATION
//  SENSEFILTSYNC_EDGE_EN defined:
//    rise/fall pulse registers are built and behave as described above.
//  SENSEFILTSYNC_EDGE_EN undefined:
//    - rise/fall ports remain present but are tied to constant 0; no pulse flops exist.
//    - r_sync behaviour and latency are identical in both builds.
// TESTING (defaults CHANNELS=4, SYNC_STAGES=2, FILT_LEN=4, edge feature on)
//  1 Hold rst high, sense_in=4'hF for 10 clks -> r_sync=0, rise=0, fall=0 throughout.
//  2 Release reset, sense_in=0 for 8 clks, then sense_in[0]=1 before edge E1 and held
//    -> r_sync[0]=1 after edge E6; rise[0]=1 for exactly that cycle; other channels stay 0.
//  3 sense_in[1]=1 for 3 clks, then 0 -> r_sync[1] stays 0, no pulse.
//    Repeat with 4 clks -> r_sync[1]=1 after the 6th edge, rise[1] pulses once.
//  4 With r_sync[0]=1 stable, set sense_in[0]=0 and hold -> r_sync[0]=0 six edges later;
//    fall[0] 1-cycle pulse; rise[0] stays 0.
//  5 sense_in[2]=1 held; assert rst asynchronously after edge E4, mid-count
//    -> all outputs 0 at once. Release and hold input high -> rise[2] fires 6 edges after
//    the first post-release edge.
//  6 Build without SENSEFILTSYNC_EDGE_EN, rerun tests 2-4 -> r_sync timing unchanged;
//    rise/fall constantly 0.

Source files
------------

// File: rtl/sensefiltsync.sv
// rtl/sensefiltsync.sv - multi-channel sense-input synchroniser with stability filter.
// Optional rise/fall pulse outputs are built only when SENSEFILTSYNC_EDGE_EN is defined.
module sensefiltsync #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                clk_sampler,
  input  logic                rst_sampler_sync,
  input  logic [CHANNELS-1:0] sense_in,
  output logic [CHANNELS-1:0] sensefiltsync_sampler_sense_in_r_sync,
  output logic [CHANNELS-1:0] sensefiltsync_sampler_sense_in_rise,
  output logic [CHANNELS-1:0] sensefiltsync_sampler_sense_in_fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sensefiltsync: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sensefiltsync: SYNC_STAGES must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("sensefiltsync: FILT_LEN must be >= 1");
  end

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  filt_q, filt_d;
  logic [CHANNELS-1:0]                  synced;
  logic [CHANNELS-1:0]                  upd;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sense_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // The counter only advances while the synced value disagrees with the filtered
  // level; any agreeing cycle restarts it, so short excursions never accumulate.
  always_comb begin
    cnt_d = '0;
    upd   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (synced[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          upd[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    filt_d = filt_q ^ upd;
  end

  always_ff @(posedge clk_sampler or posedge rst_sampler_sync) begin
    if (rst_sampler_sync) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign sensefiltsync_sampler_sense_in_r_sync = filt_q;

`ifdef SENSEFILTSYNC_EDGE_EN
  logic [CHANNELS-1:0] rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    rise_d = upd & synced;
    fall_d = upd & ~synced;
  end

  always_ff @(posedge clk_sampler or posedge rst_sampler_sync) begin
    if (rst_sampler_sync) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sensefiltsync_sampler_sense_in_rise = rise_q;
  assign sensefiltsync_sampler_sense_in_fall = fall_q;
`else
  assign sensefiltsync_sampler_sense_in_rise = '0;
  assign sensefiltsync_sampler_sense_in_fall = '0;
`endif

endmodule
